// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential execute-stage ALU (alu_seq).
// Op encodings, FSM state codes, flag bit positions and the CC reset value.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_OR  = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    // State codes kept as plain constants so older decode logic can compare them directly
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam int OF_B = 0;
    localparam int ZF_B = 1;
    localparam int SF_B = 2;

    localparam logic [2:0] CC_RST = 3'b010;

    function automatic logic [2:0] pack_flags(input logic sf, input logic zf, input logic of);
        logic [2:0] f;
        f       = 3'b000;
        f[OF_B] = of;
        f[ZF_B] = zf;
        f[SF_B] = sf;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// full 2N-bit product valid when done pulses N cycles after start.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] prod
);
    localparam int CW = $clog2(N) + 1;

    logic [2*N-1:0] acc_r;
    logic [2*N-1:0] mcand_r;
    logic [N-1:0]   mplier_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {(2*N){1'b0}};
            mcand_r  <= {(2*N){1'b0}};
            mplier_r <= {N{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= {(2*N){1'b0}};
            mcand_r  <= {{N{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= CW'(N);
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1'b1;
            mplier_r <= mplier_r >> 1'b1;
            cnt_r    <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign prod = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU with valid/ready handshake and owned CC register.
// Optional iterative multiplier is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N   = 64,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         set_cc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [2:0]   flags,
    output logic [2:0]   cc,
    output logic         illegal
);
    logic [1:0]   state_r;
    logic [N-1:0] result_r;
    logic [2:0]   flags_r;
    logic [2:0]   cc_r;
    logic         illegal_r;

    op_e          op_s;
    logic         hs_s;
    logic [N-1:0] res_s;
    logic         of_s;
    logic [2:0]   flg_s;

    assign op_s      = op_e'(op);
    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready);
    assign hs_s      = in_valid && in_ready;
    assign out_valid = (state_r == ST_HOLD);
    assign result    = result_r;
    assign flags     = flags_r;
    assign cc        = cc_r;
    assign illegal   = illegal_r;

    // Single-cycle datapath for every op except MUL
    always_comb begin
        res_s = {N{1'b0}};
        of_s  = 1'b0;
        case (op_s)
            OP_ADD: begin
                res_s = a + b;
                of_s  = (a[N-1] == b[N-1]) && (res_s[N-1] != a[N-1]);
            end
            OP_SUB: begin
                res_s = a - b;
                of_s  = (a[N-1] != b[N-1]) && (res_s[N-1] != a[N-1]);
            end
            OP_AND:  res_s = a & b;
            OP_XOR:  res_s = a ^ b;
            OP_OR:   res_s = a | b;
            OP_SHL:  res_s = a << b[SHW-1:0];
            OP_SHR:  res_s = a >> b[SHW-1:0];
            default: res_s = {N{1'b0}};
        endcase
        flg_s = pack_flags(res_s[N-1], res_s == {N{1'b0}}, of_s);
    end

`ifdef ALU_SEQ_MUL_EN
    logic           mul_start_s;
    logic           mul_done_s;
    logic [2*N-1:0] prod_s;
    logic [2:0]     mflg_s;
    logic           setcc_r;

    assign mul_start_s = hs_s && (op_s == OP_MUL);
    assign mflg_s      = pack_flags(prod_s[N-1], prod_s[N-1:0] == {N{1'b0}},
                                    |prod_s[2*N-1:N]);

    alu_seq_mul #(.N(N)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start_s),
        .a     (a),
        .b     (b),
        .done  (mul_done_s),
        .prod  (prod_s)
    );
`endif

    // Control FSM, output register and architectural condition codes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            result_r  <= {N{1'b0}};
            flags_r   <= 3'b000;
            cc_r      <= CC_RST;
            illegal_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            setcc_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (hs_s) begin
                        if (op_s == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
                            state_r <= ST_MUL;
                            setcc_r <= set_cc;
`else
                            // No multiplier: complete immediately with a zero result, leave cc alone
                            state_r   <= ST_HOLD;
                            result_r  <= {N{1'b0}};
                            flags_r   <= 3'b000;
                            illegal_r <= 1'b1;
`endif
                        end else begin
                            state_r  <= ST_HOLD;
                            result_r <= res_s;
                            flags_r  <= flg_s;
                            if (set_cc) begin
                                cc_r <= flg_s;
                            end
                        end
                    end else if ((state_r == ST_HOLD) && out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r  <= ST_HOLD;
                        result_r <= prod_s[N-1:0];
                        flags_r  <= mflg_s;
                        if (setcc_r) begin
                            cc_r <= mflg_s;
                        end
                    end
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
